// File: rtl/bcd_bin.sv
// bcd_bin: sequential 4-digit BCD to 14-bit binary converter.
// Reverse double dabble: each SHIFT cycle shifts the 30-bit working register
// right by one, then subtracts 3 from every BCD nibble that reads 8 or more.
// Fourteen iterations move the whole value into the binary field.
module bcd_bin (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] num_BCD,
   output logic [13:0] num_bin,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [29:0] sr_reg, sr_next;
   logic [13:0] bin_reg, bin_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        error_reg, error_next;

   // Working register after this cycle's shift, and after nibble correction
   logic [29:0] shifted;
   logic [29:0] corrected;
   // Per-digit flag for an operand nibble outside 0..9
   logic [3:0]  digit_bad;

   assign shifted          = {1'b0, sr_reg[29:1]};
   assign corrected[13:0]  = shifted[13:0];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         // Each BCD nibble is corrected independently from the shifted value
         assign corrected[14+4*gi +: 4] = (shifted[14+4*gi +: 4] >= 4'd8)
                                          ? shifted[14+4*gi +: 4] - 4'd3
                                          : shifted[14+4*gi +: 4];
         assign digit_bad[gi] = (num_BCD[4*gi +: 4] > 4'd9);
      end
   endgenerate

   // State and datapath registers; async reset clears everything immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         sr_reg    <= 30'd0;
         bin_reg   <= 14'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         sr_reg    <= sr_next;
         bin_reg   <= bin_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         error_reg <= error_next;
      end
   end

   // Next-state and output logic; done is a single-cycle pulse by default
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sr_next    = sr_reg;
      bin_next   = bin_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      error_next = error_reg;
      case (state_reg)
         IDLE: begin
            busy_next = 1'b0;
            if (start) begin
               if (|digit_bad) begin
                  // Bad digit: report immediately without converting
                  error_next = 1'b1;
                  bin_next   = 14'd0;
                  done_next  = 1'b1;
               end else begin
                  sr_next    = {num_BCD, 14'd0};
                  cnt_next   = 4'd0;
                  busy_next  = 1'b1;
                  state_next = SHIFT;
               end
            end
         end
         SHIFT: begin
            sr_next  = corrected;
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == 4'd13) begin
               // Final iteration: binary field is complete after the shift
               bin_next   = shifted[13:0];
               error_next = 1'b0;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign num_bin = bin_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign error   = error_reg;

endmodule

// File: tb/tb_bcd_bin.sv
// tb_bcd_bin: directed checks for bcd_bin (latency, error path, handshake,
// async reset, and a strided round trip against a decimal model).
module tb_bcd_bin;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] num_BCD;
   logic [13:0] num_bin;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   bcd_bin dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .num_BCD (num_BCD),
      .num_bin (num_bin),
      .busy    (busy),
      .done    (done),
      .error   (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Decimal model of the binary-to-BCD converter
   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One start pulse, wait (bounded) for done, check latency and results
   task automatic convert(input logic [15:0] bcd, input logic [13:0] exp_bin,
                          input logic exp_err, input int exp_lat, input string tag);
      int n;
      logic busy_ok;
      num_BCD = bcd;
      start   = 1'b1;
      step();
      start   = 1'b0;
      n       = 0;
      busy_ok = 1'b1;
      while (!done && n < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         step();
         n++;
      end
      $display("conv %s bcd=%h num_bin=%0d error=%0b latency=%0d", tag, bcd, num_bin, error, n);
      check({tag, " latency"}, n, exp_lat);
      check({tag, " num_bin"}, num_bin, exp_bin);
      check({tag, " error"}, error, exp_err);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " busy_during"}, busy_ok, 1);
      step();
      check({tag, " done_pulse"}, done, 0);
   endtask

   initial begin
      int n;
      int dones;
      rst_n   = 1'b0;
      start   = 1'b0;
      num_BCD = 16'h0000;
      #1;
      check("reset num_bin", num_bin, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset error", error, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      convert(16'h9999, 14'd9999, 1'b0, 14, "v9999");
      convert(16'h0000, 14'd0,    1'b0, 14, "v0000");
      convert(16'h1234, 14'd1234, 1'b0, 14, "v1234");
      convert(16'h0800, 14'd800,  1'b0, 14, "v0800");

      // Invalid digit: done at the accepting edge, busy never rises
      convert(16'h12A4, 14'd0,    1'b1, 0,  "bad12A4");
      convert(16'h0042, 14'd42,   1'b0, 14, "v0042");

      // Start re-pulsed mid-conversion is ignored; operand changes too
      num_BCD = 16'h0500;
      start   = 1'b1;
      step();
      start   = 1'b0;
      dones   = 0;
      for (int i = 0; i < 4; i++) step();
      start   = 1'b1;
      num_BCD = 16'h0777;
      step();
      start   = 1'b0;
      n       = 5;
      while (!done && n < 40) begin
         step();
         n++;
      end
      check("ignore latency", n, 14);
      check("ignore num_bin", num_bin, 500);
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) dones++;
      end
      $display("conv ignore bcd=0500 num_bin=%0d latency=%0d extra_dones=%0d", num_bin, n, dones);
      check("ignore extra_done", dones, 0);

      // Start held high: back-to-back conversions 15 cycles apart
      num_BCD = 16'h0001;
      start   = 1'b1;
      step();
      num_BCD = 16'h0999;
      n = 0;
      while (!done && n < 40) begin
         step();
         n++;
      end
      check("held first latency", n, 14);
      check("held first num_bin", num_bin, 1);
      check("held busy_done_overlap", busy, 0);
      n = 0;
      step();
      n++;
      while (!done && n < 40) begin
         step();
         n++;
      end
      start = 1'b0;
      $display("conv held second bcd=0999 num_bin=%0d spacing=%0d", num_bin, n);
      check("held spacing", n, 15);
      check("held second num_bin", num_bin, 999);
      step();
      check("held no third busy", busy, 0);

      // Async reset mid-conversion abandons it
      num_BCD = 16'h4321;
      start   = 1'b1;
      step();
      start   = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("pre-reset busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset busy", busy, 0);
      check("async reset num_bin", num_bin, 0);
      check("async reset error", error, 0);
      check("async reset done", done, 0);
      step();
      #2;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done || busy) dones++;
      end
      $display("conv reset-abandon bcd=4321 activity_after_release=%0d", dones);
      check("reset no done", dones, 0);
      convert(16'h4321, 14'd4321, 1'b0, 14, "v4321");

      // Round trip over a stride of the full 0..9999 range
      for (int v = 0; v <= 9999; v += 7) begin
         convert(to_bcd(v), 14'(v), 1'b0, 14, "roundtrip");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
